// File: rtl/video_timing_pkg.sv
// Raster geometry constants and helpers shared by the timing generator.
// Latency: none (elaboration-time constants and functions only).
// Backpressure: not applicable.
package video_timing_pkg;

  // Derived per-axis positions, all counted from the start of the active area
  typedef struct packed {
    int unsigned total;
    int unsigned sync_start;
    int unsigned sync_end;
  } axis_geom_t;

  // Fold active/porch/sync widths into TOTAL, sync START and sync END
  function automatic axis_geom_t axis_geom(input int unsigned active,
                                           input int unsigned fp,
                                           input int unsigned sync,
                                           input int unsigned bp);
    axis_geom_t g;
    g.total      = active + fp + sync + bp;
    g.sync_start = active + fp;
    g.sync_end   = active + fp + sync;
    return g;
  endfunction

  // VGA 640x480@60, 25.175 MHz pixel clock
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // PC-8001 640x200 text screen, each source line scanned twice (640x400@70)
  localparam int unsigned PC8K_H_ACTIVE = 640;
  localparam int unsigned PC8K_H_FP     = 16;
  localparam int unsigned PC8K_H_SYNC   = 96;
  localparam int unsigned PC8K_H_BP     = 48;
  localparam int unsigned PC8K_V_ACTIVE = 400;
  localparam int unsigned PC8K_V_FP     = 12;
  localparam int unsigned PC8K_V_SYNC   = 2;
  localparam int unsigned PC8K_V_BP     = 35;

endpackage

// File: rtl/vt_axis_cnt.sv
// One raster axis counter: 0..TOTAL-1 with wrap flag and look-ahead value.
// Latency: cnt follows nxt_cnt on the next clk edge; wrap is combinational.
// Backpressure: none; holds while adv is low, restart parks it at TOTAL-1.
module vt_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 800,
  parameter int          CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             restart,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] nxt_cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap    = (cnt_q == LAST);
  assign cnt     = cnt_q;
  assign nxt_cnt = cnt_d;

  // Next position: restart parks at the last position so the next advance lands on 0
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = LAST;
    end else if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Position register, reset to the last position of the axis
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, sync/DE/blank decodes and strobes.
// Latency: all outputs registered on the same edge as H_CNT/V_CNT (zero decode lag).
// Backpressure: EN low freezes everything and gates strobes; RESTART parks at origin-1.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          CNT_W    = 10,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CE_DIV   = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             RESTART,
  output logic             PIX_CE,
  output logic [CNT_W-1:0] H_CNT,
  output logic [CNT_W-1:0] V_CNT,
  output logic             HS,
  output logic             VS,
  output logic             DE,
  output logic             VBLANK,
  output logic             LINE_START,
  output logic             FRAME_START
);

  localparam axis_geom_t HG = axis_geom(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam axis_geom_t VG = axis_geom(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if ((HG.total > 2**CNT_W) || (VG.total > 2**CNT_W) ||
        (H_ACTIVE == 0) || (H_SYNC == 0) || (V_ACTIVE == 0) || (V_SYNC == 0) ||
        (CE_DIV < 1) || (CE_DIV > 16)) begin : g_bad_geom
      $error("video_timing_gen: illegal geometry or CE_DIV");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HG.sync_start);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HG.sync_end);
  // With no back porch, HS runs to the end of the line and HS_END is not a position
  localparam bit               HS_TO_END  = (HG.sync_end == HG.total);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(VG.sync_start);
  // With no back porch, VS releases on line 0
  localparam logic [CNT_W-1:0] VS_OFF_C   = CNT_W'(VG.sync_end % VG.total);
  localparam logic [3:0]       PRESC_LAST = 4'(CE_DIV - 1);

  logic [3:0]       presc_q, presc_d;
  logic             tick;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  logic             hs_act, de_nxt, vb_nxt;
  logic             pix_ce_q, ls_q, fs_q, hs_q, vs_q, de_q, vb_q;

  assign tick = EN & (presc_q == PRESC_LAST);

  vt_axis_cnt #(.TOTAL(HG.total), .CNT_W(CNT_W)) u_h_cnt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .adv     (tick),
    .restart (RESTART),
    .cnt     (H_CNT),
    .nxt_cnt (h_nxt),
    .wrap    (h_wrap)
  );

  vt_axis_cnt #(.TOTAL(VG.total), .CNT_W(CNT_W)) u_v_cnt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .adv     (tick & h_wrap),
    .restart (RESTART),
    .cnt     (V_CNT),
    .nxt_cnt (v_nxt),
    .wrap    (v_wrap)
  );

  // Prescaler advance; holds its phase while EN is low
  always_comb begin
    presc_d = presc_q;
    if (tick) begin
      presc_d = '0;
    end else if (EN) begin
      presc_d = presc_q + 4'd1;
    end
  end

  // Level decodes of the position the counters are about to take
  always_comb begin
    hs_act = (h_nxt >= HS_START_C) && (HS_TO_END || (h_nxt < HS_END_C));
    de_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
    vb_nxt = (v_nxt >= V_ACT_C);
  end

  // Prescaler and output registers; levels update only on pixel ticks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q  <= '0;
      pix_ce_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      vb_q     <= 1'b1;
    end else if (RESTART) begin
      presc_q  <= '0;
      pix_ce_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      vb_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      pix_ce_q <= tick;
      // Advancing out of the last pixel means the new position is column 0 / origin
      ls_q     <= tick & h_wrap;
      fs_q     <= tick & h_wrap & v_wrap;
      if (tick) begin
        de_q <= de_nxt;
        vb_q <= vb_nxt;
        hs_q <= hs_act ? HS_POL : ~HS_POL;
        // VS edges only at the HS leading edge so both syncs move together
        if (h_nxt == HS_START_C) begin
          if (v_nxt == VS_START_C) begin
            vs_q <= VS_POL;
          end else if (v_nxt == VS_OFF_C) begin
            vs_q <= ~VS_POL;
          end
        end
      end
    end
  end

  assign PIX_CE      = pix_ce_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign DE          = de_q;
  assign VBLANK      = vb_q;

endmodule
